// File: rtl/stream_recorder_pkg.sv
// stream_recorder_pkg: shared types and width helpers for the stream recorder.
//   rec_state_e - recorder control states
//   ptr_width   - buffer address width for a given depth
//   cnt_width   - occupancy counter width (must represent 0..depth)
package stream_recorder_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StReadout = 2'd3
   } rec_state_e;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/recorder_ram.sv
// recorder_ram: DEPTH x WIDTH simple dual-port RAM, synchronous write, registered read.
//   clock   - write and read clock
//   rst     - synchronous reset of the read data register only
//   wr_en   - write strobe; wr_data stored at wr_addr
//   rd_en   - read strobe; mem[rd_addr] appears on rd_data after the edge
//   rd_data - registered read word, holds its value between reads
module recorder_ram
   import stream_recorder_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = ptr_width(DEPTH)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/stream_recorder.sv
// stream_recorder: arm / trigger / capture / readout recorder for a valid-qualified word stream.
//   clock, rst           - single clock, synchronous active-high reset
//   arm                  - pulse; starts a capture session from IDLE
//   trigger              - level; starts capture while ARMED
//   stop                 - pulse; ends capture
//   cap_valid, cap_data  - sample strobe and value
//   rd_en                - read request during READOUT
//   rd_data, rd_valid    - registered read word and its one-cycle strobe
//   count                - entries held (0..DEPTH)
//   busy, done           - ARMED/CAPTURE and READOUT indicators
//   overflow             - sticky; an entry was overwritten in circular mode
module stream_recorder
   import stream_recorder_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WRAP  = 0,
   localparam int unsigned PW = ptr_width(DEPTH),
   localparam int unsigned CW = cnt_width(DEPTH)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             arm,
   input  logic             trigger,
   input  logic             stop,
   input  logic             cap_valid,
   input  logic [WIDTH-1:0] cap_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [CW-1:0]    count,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam logic [CW-1:0] Full = CW'(DEPTH);

   rec_state_e    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          rd_valid_q, rd_valid_d;
   logic          ram_wr, ram_rd;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      rd_valid_d = 1'b0;
      ram_wr     = 1'b0;
      ram_rd     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (arm) begin
               state_d    = StArmed;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               count_d    = '0;
               overflow_d = 1'b0;
            end
         end
         StArmed, StCapture: begin
            // The trigger cycle is treated as the first capture cycle.
            if (state_q == StCapture || trigger) begin
               if (cap_valid && (WRAP != 0 || count_q != Full)) begin
                  ram_wr   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (count_q == Full) begin
                     // Circular mode: drop the oldest entry.
                     rd_ptr_d   = rd_ptr_q + 1'b1;
                     overflow_d = 1'b1;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
               if (stop) begin
                  state_d = StReadout;
               end else if (WRAP == 0 && count_d == Full) begin
                  state_d = StReadout;
               end else begin
                  state_d = StCapture;
               end
            end
         end
         StReadout: begin
            // Leaving only once empty gives the last word's rd_valid its cycle.
            if (count_q == '0) begin
               state_d = StIdle;
            end else if (rd_en) begin
               ram_rd     = 1'b1;
               rd_valid_d = 1'b1;
               rd_ptr_d   = rd_ptr_q + 1'b1;
               count_d    = count_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   recorder_ram #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_ram (
      .clock  (clock),
      .rst    (rst),
      .wr_en  (ram_wr),
      .wr_addr(wr_ptr_q),
      .wr_data(cap_data),
      .rd_en  (ram_rd),
      .rd_addr(rd_ptr_q),
      .rd_data(rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign busy     = (state_q == StArmed) || (state_q == StCapture);
   assign done     = (state_q == StReadout);

endmodule

// File: tb/tb_stream_recorder.sv
// tb_stream_recorder: two recorders (DEPTH=4, WRAP=0 and WRAP=1) fed the same stimulus,
// each checked every cycle against a queue-based behavioural model, plus directed scenarios
// with hand-computed expectations.
module tb_stream_recorder;

   logic       clock;
   logic       rst, arm, trigger, stop, cap_valid, rd_en;
   logic [3:0] cap_data;
   logic [3:0] rd_data  [2];
   logic       rd_valid [2];
   logic [2:0] count    [2];
   logic       busy     [2];
   logic       done     [2];
   logic       overflow [2];

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 0;

   // Model: 0 idle, 1 armed, 2 capture, 3 readout; buffer held as a queue.
   int         mst  [2];
   logic [3:0] mq   [2][$];
   bit         mov  [2];
   logic [3:0] mrdd [2];
   bit         mrdv [2];

   stream_recorder #(.WIDTH(4), .DEPTH(4), .WRAP(0)) u_dut0 (
      .clock(clock), .rst(rst), .arm(arm), .trigger(trigger), .stop(stop),
      .cap_valid(cap_valid), .cap_data(cap_data), .rd_en(rd_en),
      .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .count(count[0]),
      .busy(busy[0]), .done(done[0]), .overflow(overflow[0])
   );

   stream_recorder #(.WIDTH(4), .DEPTH(4), .WRAP(1)) u_dut1 (
      .clock(clock), .rst(rst), .arm(arm), .trigger(trigger), .stop(stop),
      .cap_valid(cap_valid), .cap_data(cap_data), .rd_en(rd_en),
      .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .count(count[1]),
      .busy(busy[1]), .done(done[1]), .overflow(overflow[1])
   );

   initial clock = 0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int w, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, w, act, exp, $time);
      end
   endtask

   task automatic model_step(input int w);
      bit v;
      v = 0;
      if (rst) begin
         mst[w] = 0; mq[w].delete(); mov[w] = 0; mrdd[w] = 0; mrdv[w] = 0;
         return;
      end
      case (mst[w])
         0: if (arm) begin mst[w] = 1; mq[w].delete(); mov[w] = 0; end
         1, 2: if (mst[w] == 2 || trigger) begin
            if (cap_valid) begin
               if (mq[w].size() < 4) mq[w].push_back(cap_data);
               else if (w == 1) begin
                  mq[w].delete(0); mq[w].push_back(cap_data); mov[w] = 1;
               end
            end
            if (stop) mst[w] = 3;
            else if (w == 0 && mq[w].size() == 4) mst[w] = 3;
            else mst[w] = 2;
         end
         default: begin
            if (mq[w].size() == 0) mst[w] = 0;
            else if (rd_en) begin mrdd[w] = mq[w].pop_front(); v = 1; end
         end
      endcase
      mrdv[w] = v;
   endtask

   always @(posedge clock) begin
      for (int w = 0; w < 2; w++) model_step(w);
   end

   always @(negedge clock) begin
      if (checking) begin
         for (int w = 0; w < 2; w++) begin
            check("model_busy", w, busy[w], (mst[w] == 1 || mst[w] == 2));
            check("model_done", w, done[w], (mst[w] == 3));
            check("model_count", w, count[w], mq[w].size());
            check("model_overflow", w, overflow[w], mov[w]);
            check("model_rd_valid", w, rd_valid[w], mrdv[w]);
            check("model_rd_data", w, rd_data[w], mrdd[w]);
         end
      end
   end

   task automatic step(input bit r, a, t, s, v, input logic [3:0] d, input bit re);
      rst = r; arm = a; trigger = t; stop = s; cap_valid = v; cap_data = d; rd_en = re;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 4'h0, 0);
   endtask

   task automatic rd_pair(input logic [3:0] e0, e1);
      step(0, 0, 0, 0, 0, 4'h0, 1);
      check("rd_valid", 0, rd_valid[0], 1);
      check("rd_data", 0, rd_data[0], e0);
      check("rd_valid", 1, rd_valid[1], 1);
      check("rd_data", 1, rd_data[1], e1);
   endtask

   initial begin
      rst = 1; arm = 0; trigger = 0; stop = 0; cap_valid = 0; cap_data = 0; rd_en = 0;
      for (int w = 0; w < 2; w++) begin
         mst[w] = 0; mov[w] = 0; mrdd[w] = 0; mrdv[w] = 0;
      end
      repeat (2) @(negedge clock);
      checking = 1;
      check("reset_busy", 0, busy[0], 0);
      check("reset_count", 0, count[0], 0);
      check("reset_rd_valid", 0, rd_valid[0], 0);
      check("reset_rd_data", 1, rd_data[1], 0);

      // 1: fill to DEPTH in stop-when-full mode
      step(0, 1, 0, 0, 0, 4'h0, 0);
      step(0, 0, 1, 0, 1, 4'h1, 0);
      step(0, 0, 0, 0, 1, 4'h2, 0);
      step(0, 0, 0, 0, 1, 4'h3, 0);
      step(0, 0, 0, 0, 1, 4'h4, 0);
      check("t1_done", 0, done[0], 1);
      check("t1_count", 0, count[0], 4);
      check("t1_busy_wrap", 1, busy[1], 1);
      step(0, 0, 0, 1, 0, 4'h0, 0);
      rd_pair(4'h1, 4'h1);
      rd_pair(4'h2, 4'h2);
      rd_pair(4'h3, 4'h3);
      rd_pair(4'h4, 4'h4);
      idle(1);
      check("t1_rd_valid_off", 0, rd_valid[0], 0);
      check("t1_idle", 0, done[0], 0);
      idle(1);

      // 2: sample before trigger is dropped
      step(0, 1, 0, 0, 0, 4'h0, 0);
      step(0, 0, 0, 0, 1, 4'hA, 0);
      step(0, 0, 1, 0, 0, 4'h0, 0);
      step(0, 0, 0, 1, 1, 4'hB, 0);
      check("t2_count", 0, count[0], 1);
      check("t2_done", 0, done[0], 1);
      rd_pair(4'hB, 4'hB);
      idle(2);

      // 3: circular overwrite
      step(0, 1, 0, 0, 0, 4'h0, 0);
      step(0, 0, 1, 0, 1, 4'h1, 0);
      for (int i = 2; i <= 6; i++) step(0, 0, 0, 0, 1, 4'(i), 0);
      step(0, 0, 0, 1, 0, 4'h0, 0);
      check("t3_overflow", 1, overflow[1], 1);
      check("t3_count", 1, count[1], 4);
      check("t3_no_overflow", 0, overflow[0], 0);
      rd_pair(4'h1, 4'h3);
      rd_pair(4'h2, 4'h4);
      rd_pair(4'h3, 4'h5);
      rd_pair(4'h4, 4'h6);
      idle(2);

      // 4: sample in the stop cycle is kept
      step(0, 1, 0, 0, 0, 4'h0, 0);
      step(0, 0, 1, 0, 1, 4'h1, 0);
      step(0, 0, 0, 0, 1, 4'h2, 0);
      step(0, 0, 0, 1, 1, 4'h7, 0);
      check("t4_count", 0, count[0], 3);
      rd_pair(4'h1, 4'h1);
      rd_pair(4'h2, 4'h2);
      rd_pair(4'h7, 4'h7);
      idle(2);

      // 5: reset mid-capture, then a fresh session
      step(0, 1, 0, 0, 0, 4'h0, 0);
      step(0, 0, 1, 0, 1, 4'h1, 0);
      step(0, 0, 0, 0, 1, 4'h2, 0);
      step(1, 0, 0, 0, 1, 4'h5, 0);
      check("t5_busy", 0, busy[0], 0);
      check("t5_count", 0, count[0], 0);
      check("t5_overflow", 1, overflow[1], 0);
      check("t5_rd_valid", 0, rd_valid[0], 0);
      step(0, 1, 0, 0, 0, 4'h0, 0);
      step(0, 0, 1, 0, 1, 4'hC, 0);
      step(0, 0, 0, 1, 0, 4'h0, 0);
      rd_pair(4'hC, 4'hC);
      step(0, 0, 0, 0, 0, 4'h0, 1);
      check("t5_extra_read", 0, rd_valid[0], 0);
      idle(2);

      // 6: empty session; arm during capture ignored
      step(0, 1, 0, 0, 0, 4'h0, 0);
      step(0, 0, 1, 0, 0, 4'h0, 0);
      step(0, 1, 0, 0, 0, 4'h0, 0);
      check("t6_busy", 0, busy[0], 1);
      step(0, 0, 0, 1, 0, 4'h0, 0);
      check("t6_done", 0, done[0], 1);
      check("t6_count", 0, count[0], 0);
      step(0, 0, 0, 0, 0, 4'h0, 1);
      check("t6_rd_valid", 0, rd_valid[0], 0);
      check("t6_idle", 0, done[0], 0);
      check("t6_not_busy", 0, busy[0], 0);
      idle(2);

      // Random traffic against the models
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
              1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
